// File: rtl/ps2_keyboard_rx.sv
// System-clocked PS/2 keyboard receiver: synchronise and filter the bus, frame 11-bit packets,
// fold E0/F0 prefixes into flags and queue key events in a first-word fall-through FIFO.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             ps2_clk,
  input  logic                             ps2_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [7:0]                       out_code,
  output logic                             out_ext,
  output logic                             out_brk,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             frame_err,
  output logic                             overflow
);

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

  logic clkMeta_q, clkSync_q, dataMeta_q, dataSync_q;
  logic filtClk_q, filtClk_d, fallEvt_q;
  logic [FW-1:0] filtCnt_q, filtCnt_d;
  state_t state_q, state_d;
  logic [7:0] shift_q, byte_q;
  logic [2:0] bitCnt_q;
  logic parity_q, byteValid_q, frameErr_q, extPend_q, brkPend_q, overflow_q;
  logic [TW-1:0] toCnt_q;
  logic timeout, startEn, shiftEn, parityEn, stopEn, frameOk, frameBad;
  logic push, full, pop, doWrite;
  logic [9:0] pushData;
  logic [9:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [LW-1:0] fifoLevel_q;

  // Synchronisers reset to the idle-high bus level so release cannot fake an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
    end else begin
      clkMeta_q  <= ps2_clk;
      clkSync_q  <= clkMeta_q;
      dataMeta_q <= ps2_data;
      dataSync_q <= dataMeta_q;
    end
  end

  always_comb begin
    filtCnt_d = filtCnt_q;
    filtClk_d = filtClk_q;
    if (clkSync_q == filtClk_q) begin
      filtCnt_d = '0;
    end else if (filtCnt_q == FILT_LAST) begin
      filtCnt_d = '0;
      filtClk_d = clkSync_q;
    end else begin
      filtCnt_d = filtCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filtClk_q <= 1'b1;
      filtCnt_q <= '0;
      fallEvt_q <= 1'b0;
    end else begin
      filtClk_q <= filtClk_d;
      filtCnt_q <= filtCnt_d;
      fallEvt_q <= filtClk_q & ~filtClk_d;
    end
  end

  assign timeout = (state_q != IDLE) && !fallEvt_q && (toCnt_q == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fallEvt_q) begin
      unique case (state_q)
        IDLE:    if (!dataSync_q) state_d = SHIFT;
        SHIFT:   if (bitCnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    startEn  = fallEvt_q && (state_q == IDLE) && !dataSync_q;
    shiftEn  = fallEvt_q && (state_q == SHIFT);
    parityEn = fallEvt_q && (state_q == PARITY);
    stopEn   = fallEvt_q && (state_q == STOP);
    frameOk  = stopEn && dataSync_q && (^{shift_q, parity_q});
    frameBad = (stopEn && !frameOk) || timeout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= '0;
      bitCnt_q    <= '0;
      parity_q    <= 1'b0;
      toCnt_q     <= '0;
      byteValid_q <= 1'b0;
      byte_q      <= '0;
      frameErr_q  <= 1'b0;
    end else begin
      if (startEn) bitCnt_q <= '0;
      if (shiftEn) begin
        shift_q  <= {dataSync_q, shift_q[7:1]};
        bitCnt_q <= bitCnt_q + 1'b1;
      end
      if (parityEn) parity_q <= dataSync_q;
      toCnt_q     <= ((state_q == IDLE) || fallEvt_q) ? '0 : toCnt_q + 1'b1;
      byteValid_q <= frameOk;
      if (frameOk) byte_q <= shift_q;
      frameErr_q  <= frameBad;
    end
  end

  // Prefix bytes only arm flags; a completed key byte consumes and clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      extPend_q <= 1'b0;
      brkPend_q <= 1'b0;
    end else if (frameBad) begin
      extPend_q <= 1'b0;
      brkPend_q <= 1'b0;
    end else if (byteValid_q) begin
      if (byte_q == 8'hE0)      extPend_q <= 1'b1;
      else if (byte_q == 8'hF0) brkPend_q <= 1'b1;
      else begin
        extPend_q <= 1'b0;
        brkPend_q <= 1'b0;
      end
    end
  end

  assign push     = byteValid_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);
  assign pushData = {extPend_q, brkPend_q, byte_q};
  assign full     = (fifoLevel_q == LVL_FULL);
  assign pop      = out_valid && out_ready;
  assign doWrite  = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr_q] <= pushData;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoLevel_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)     rdPtr_q <= rdPtr_q + 1'b1;
      if (doWrite && !pop)      fifoLevel_q <= fifoLevel_q + 1'b1;
      else if (!doWrite && pop) fifoLevel_q <= fifoLevel_q - 1'b1;
      overflow_q <= push && full && !pop;
    end
  end

  // Head fields are forced to zero while empty so the memory needs no reset.
  assign out_valid  = (fifoLevel_q != '0);
  assign out_code   = out_valid ? mem[rdPtr_q][7:0] : 8'h00;
  assign out_brk    = out_valid ? mem[rdPtr_q][8] : 1'b0;
  assign out_ext    = out_valid ? mem[rdPtr_q][9] : 1'b0;
  assign fifo_level = fifoLevel_q;
  assign frame_err  = frameErr_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: drives bit-level PS/2 frames and compares the
// queued key events against a byte-level prefix/FIFO model.
module tb_ps2_keyboard_rx;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int FIFO_DEPTH     = 8;
  localparam int HALF           = 20;

  logic       clk = 1'b0;
  logic       reset_n, ps2_clk, ps2_data, out_ready;
  logic       out_valid, out_ext, out_brk, frame_err, overflow;
  logic [7:0] out_code;
  logic [3:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int errPulses = 0;
  int ovfPulses = 0;
  int expErr = 0;
  int expOvf = 0;
  logic [9:0] expQ[$];
  logic extM = 1'b0;
  logic brkM = 1'b0;

  ps2_keyboard_rx #(
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_ext(out_ext), .out_brk(out_brk), .fifo_level(fifo_level),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) errPulses++;
    if (overflow === 1'b1) ovfPulses++;
  end

  // Byte-level reference: prefixes arm flags, other bytes enqueue or overflow.
  task automatic modelByte(input logic [7:0] b);
    if (b == 8'hE0) extM = 1'b1;
    else if (b == 8'hF0) brkM = 1'b1;
    else begin
      if (expQ.size() < FIFO_DEPTH) expQ.push_back({extM, brkM, b});
      else expOvf++;
      extM = 1'b0;
      brkM = 1'b0;
    end
  endtask

  task automatic modelError();
    extM = 1'b0;
    brkM = 1'b0;
    expErr++;
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop,
                           input int nBits, input bit glitch);
    logic [10:0] bits;
    int g;
    bits = {~badStop, (badPar ? ^b : ~(^b)), b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (6) @(negedge clk);
      if (glitch) begin
        g = $urandom_range(1, FILTER_LEN - 3);
        ps2_clk = 1'b0;
        repeat (g) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 6 - g) @(negedge clk);
      end else begin
        repeat (HALF - 6) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (12) @(negedge clk);
      if (glitch) begin
        g = $urandom_range(1, FILTER_LEN - 3);
        ps2_clk = 1'b1;
        repeat (g) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8 - g) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF + 30) @(negedge clk);
  endtask

  task automatic sendGood(input logic [7:0] b, input bit glitch);
    sendFrame(b, 1'b0, 1'b0, 11, glitch);
    modelByte(b);
  endtask

  task automatic popOne(output logic v, output logic [7:0] c, output logic e, output logic k);
    @(negedge clk);
    v = out_valid; c = out_code; e = out_ext; k = out_brk;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({out_valid, out_code, out_ext, out_brk, frame_err, overflow} !== 13'd0) begin
      errors++; $display("[TB] FAIL reset_outputs got %h want 0",
        {out_valid, out_code, out_ext, out_brk, frame_err, overflow});
    end
    checks++;
    if (fifo_level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", fifo_level); end
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || errPulses !== 0) begin
      errors++; $display("[TB] FAIL reset_release got valid=%b err=%0d want 0 0", out_valid, errPulses);
    end
  endtask

  task automatic test_single();
    logic v, e, k; logic [7:0] c;
    sendGood(8'h1C, 1'b0);
    checks++;
    if ({out_valid, out_ext, out_brk, out_code} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
      errors++; $display("[TB] FAIL single_head got v=%b e=%b b=%b c=%h want 1 0 0 1c",
        out_valid, out_ext, out_brk, out_code);
    end
    checks++;
    if (fifo_level !== 4'd1) begin errors++; $display("[TB] FAIL single_level got %0d want 1", fifo_level); end
    popOne(v, c, e, k);
    void'(expQ.pop_front());
    checks++;
    if (fifo_level !== 4'd0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_pop got level=%0d valid=%b want 0 0", fifo_level, out_valid);
    end
  endtask

  task automatic test_prefixes();
    logic v, e, k; logic [7:0] c; logic [9:0] exp; int pre; logic [7:0] code;
    sendGood(8'hF0, 1'b0); sendGood(8'h1C, 1'b0);
    sendGood(8'hE0, 1'b0); sendGood(8'hF0, 1'b0); sendGood(8'h75, 1'b0);
    for (int n = 0; n < 4; n++) begin
      pre = $urandom_range(0, 7);
      if (pre[2]) begin
        if (pre[0]) sendGood(8'hF0, 1'b0);
        if (pre[1]) begin sendGood(8'hE0, 1'b0); sendGood(8'hE0, 1'b0); end
      end else begin
        if (pre[1]) sendGood(8'hE0, 1'b0);
        if (pre[0]) begin sendGood(8'hF0, 1'b0); sendGood(8'hF0, 1'b0); end
      end
      code = 8'($urandom_range(0, 255));
      if (code == 8'hE0 || code == 8'hF0) code = 8'h5A;
      sendGood(code, 1'b0);
    end
    checks++;
    if (fifo_level !== 4'(expQ.size())) begin
      errors++; $display("[TB] FAIL pfx_level got %0d want %0d", fifo_level, expQ.size());
    end
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      popOne(v, c, e, k);
      checks++;
      if (v !== 1'b1 || {e, k, c} !== exp) begin
        errors++; $display("[TB] FAIL pfx_entry got v=%b ext=%b brk=%b code=%h want 1 %b %b %h",
          v, e, k, c, exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_frame_error();
    logic v, e, k; logic [7:0] c; logic [9:0] exp;
    sendGood(8'hF0, 1'b0);
    sendFrame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
    modelError();
    checks++;
    if (errPulses !== expErr || fifo_level !== 4'd0) begin
      errors++; $display("[TB] FAIL parity_err got pulses=%0d level=%0d want %0d 0", errPulses, fifo_level, expErr);
    end
    sendFrame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 11, 1'b0);
    modelError();
    checks++;
    if (errPulses !== expErr || fifo_level !== 4'd0) begin
      errors++; $display("[TB] FAIL stop_err got pulses=%0d level=%0d want %0d 0", errPulses, fifo_level, expErr);
    end
    sendGood(8'h1C, 1'b0);
    exp = expQ.pop_front();
    popOne(v, c, e, k);
    checks++;
    if (v !== 1'b1 || {e, k, c} !== exp) begin
      errors++; $display("[TB] FAIL after_err got v=%b ext=%b brk=%b code=%h want 1 %b %b %h",
        v, e, k, c, exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic test_timeout();
    logic v, e, k; logic [7:0] c; logic [9:0] exp;
    sendGood(8'hE0, 1'b0);
    sendFrame(8'h1C, 1'b0, 1'b0, 4, 1'b0);
    repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
    modelError();
    checks++;
    if (errPulses !== expErr || fifo_level !== 4'd0) begin
      errors++; $display("[TB] FAIL timeout_err got pulses=%0d level=%0d want %0d 0", errPulses, fifo_level, expErr);
    end
    sendGood(8'h1C, 1'b0);
    exp = expQ.pop_front();
    popOne(v, c, e, k);
    checks++;
    if (v !== 1'b1 || {e, k, c} !== exp) begin
      errors++; $display("[TB] FAIL after_timeout got v=%b ext=%b brk=%b code=%h want 1 %b %b %h",
        v, e, k, c, exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic test_overflow();
    logic v, e, k; logic [7:0] c; logic [9:0] exp;
    for (int i = 1; i <= FIFO_DEPTH + 1; i++) sendGood(8'(i), 1'b0);
    checks++;
    if (fifo_level !== 4'(FIFO_DEPTH)) begin
      errors++; $display("[TB] FAIL ovf_level got %0d want %0d", fifo_level, FIFO_DEPTH);
    end
    checks++;
    if (ovfPulses !== expOvf) begin
      errors++; $display("[TB] FAIL ovf_pulses got %0d want %0d", ovfPulses, expOvf);
    end
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      popOne(v, c, e, k);
      checks++;
      if (v !== 1'b1 || {e, k, c} !== exp) begin
        errors++; $display("[TB] FAIL ovf_drain got v=%b code=%h want 1 %h", v, c, exp[7:0]);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      errors++; $display("[TB] FAIL ovf_empty got valid=%b level=%0d want 0 0", out_valid, fifo_level);
    end
  endtask

  task automatic test_glitch();
    logic v, e, k; logic [7:0] c; logic [9:0] exp; logic [7:0] code;
    for (int n = 0; n < 4; n++) begin
      code = 8'($urandom_range(0, 255));
      if (code == 8'hE0 || code == 8'hF0) code = 8'hA5;
      sendGood(code, 1'b1);
    end
    checks++;
    if (fifo_level !== 4'(expQ.size()) || errPulses !== expErr) begin
      errors++; $display("[TB] FAIL glitch_level got level=%0d err=%0d want %0d %0d",
        fifo_level, errPulses, expQ.size(), expErr);
    end
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      popOne(v, c, e, k);
      checks++;
      if (v !== 1'b1 || {e, k, c} !== exp) begin
        errors++; $display("[TB] FAIL glitch_entry got v=%b code=%h want 1 %h", v, c, exp[7:0]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic v, e, k; logic [7:0] c; logic [9:0] exp;
    sendGood(8'hF0, 1'b0);
    sendFrame(8'h3A, 1'b0, 1'b0, 5, 1'b0);
    reset_n = 1'b0;
    extM = 1'b0; brkM = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_code, out_ext, out_brk, frame_err, overflow, fifo_level} !== 17'd0) begin
      errors++; $display("[TB] FAIL midreset_outputs got %h want 0",
        {out_valid, out_code, out_ext, out_brk, frame_err, overflow, fifo_level});
    end
    reset_n = 1'b1;
    repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
    checks++;
    if (errPulses !== expErr || fifo_level !== 4'd0) begin
      errors++; $display("[TB] FAIL midreset_quiet got pulses=%0d level=%0d want %0d 0", errPulses, fifo_level, expErr);
    end
    sendGood(8'h1C, 1'b0);
    exp = expQ.pop_front();
    popOne(v, c, e, k);
    checks++;
    if (v !== 1'b1 || {e, k, c} !== exp) begin
      errors++; $display("[TB] FAIL after_midreset got v=%b ext=%b brk=%b code=%h want 1 %b %b %h",
        v, e, k, c, exp[9], exp[8], exp[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefixes();
    test_frame_error();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
